pipe_rca_adder: RTL

Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready handshake. It splits a WIDTH-bit carry chain into STAGES registered slices and accepts one operation per cycle. It reports carry-out and signed overflow. It sits in the datapath wherever a wide add/sub must close timing at clock rate, and it replaces single-cycle flat adders.

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_slice.sv | 27 ++
 rtl/pipe_rca_adder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined ripple-carry adder.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_t;

  function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // Legal when the carry chain splits into equal, non-empty slices.
  function automatic bit params_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry adder; also exposes the carry into its top bit.
module adder_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic carry;

  always_comb begin
    carry = ci;
    c_msb = ci;
    s     = '0;
    for (int unsigned i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) c_msb = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one carry slice per stage, skewed operands,
// de-skewed result, valid/ready handshake with a global stall.
module pipe_rca_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SliceW = slice_w(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_rca_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             stall;
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             cmsb_d, cmsb_q;

  always_comb begin
    stall    = out_valid && !out_ready;
    advance  = !stall;
    in_ready = !stall && !rst;
    b_eff    = sub ? ~b : b;
    c0       = sub | cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Result bits accumulated so far: slices 0..k.
    localparam int unsigned SumW = (k + 1) * SliceW;

    logic [SliceW-1:0] op_a, op_b, s;
    logic              ci, co, cm;
    logic              vld_in, vld_d, vld_q;
    logic              cry_d, cry_q;
    logic [SumW-1:0]   sum_in, sum_d, sum_q;

    if (k == 0) begin : g_head
      assign op_a   = a[SliceW-1:0];
      assign op_b   = b_eff[SliceW-1:0];
      assign ci     = c0;
      assign vld_in = in_valid;
      assign sum_in = s;
    end else begin : g_body
      assign op_a   = g_stage[k-1].g_skew.opa_q[SliceW-1:0];
      assign op_b   = g_stage[k-1].g_skew.opb_q[SliceW-1:0];
      assign ci     = g_stage[k-1].cry_q;
      assign vld_in = g_stage[k-1].vld_q;
      assign sum_in = {s, g_stage[k-1].sum_q};
    end

    adder_slice #(
      .SLICE(SliceW)
    ) u_slice (
      .a    (op_a),
      .b    (op_b),
      .ci   (ci),
      .s    (s),
      .co   (co),
      .c_msb(cm)
    );

    always_comb begin
      vld_d = vld_q;
      cry_d = cry_q;
      sum_d = sum_q;
      if (advance) begin
        vld_d = vld_in;
        cry_d = co;
        sum_d = sum_in;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        cry_q <= 1'b0;
        sum_q <= '0;
      end else begin
        vld_q <= vld_d;
        cry_q <= cry_d;
        sum_q <= sum_d;
      end
    end

    // Operand slices not yet consumed travel alongside the partial result.
    if (k < STAGES - 1) begin : g_skew
      localparam int unsigned OpW = WIDTH - SumW;

      logic [OpW-1:0] opa_in, opb_in, opa_d, opb_d, opa_q, opb_q;
      logic           unused_cm;

      assign unused_cm = cm;

      if (k == 0) begin : g_src
        assign opa_in = a[WIDTH-1:SliceW];
        assign opb_in = b_eff[WIDTH-1:SliceW];
      end else begin : g_src
        assign opa_in = g_stage[k-1].g_skew.opa_q[WIDTH-SumW+SliceW-1:SliceW];
        assign opb_in = g_stage[k-1].g_skew.opb_q[WIDTH-SumW+SliceW-1:SliceW];
      end

      always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        if (advance) begin
          opa_d = opa_in;
          opb_d = opb_in;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          opa_q <= '0;
          opb_q <= '0;
        end else begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end
    end
  end

  always_comb begin
    cmsb_d = cmsb_q;
    if (advance) cmsb_d = g_stage[STAGES-1].cm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmsb_q <= 1'b0;
    end else begin
      cmsb_q <= cmsb_d;
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].cry_q;
  assign ovf       = g_stage[STAGES-1].cry_q ^ cmsb_q;

endmodule
